// File: rtl/evm_pkg.sv
// Shared EVM definitions: ballot FSM state encoding, candidate count and
// the one-hot helpers used by both the ballot unit and the tally block.
`timescale 1ns/1ps
package evm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t LOCKED  = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t PRESS   = 2'd2;
    localparam state_t RELEASE = 2'd3;

    localparam int NUM_CANDIDATES = 6;

    // One-hot candidate vector to candidate number 1..6 (0 when empty).
    function automatic logic [2:0] encode(input logic [NUM_CANDIDATES-1:0] onehot);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (onehot[i]) begin
                id = 3'(i + 1);
            end
        end
        return id;
    endfunction

    // Number of buttons pressed at once.
    function automatic logic [2:0] popcount(input logic [NUM_CANDIDATES-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/evm_sync2.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, enables).
`timescale 1ns/1ps
module evm_sync2 #(
    parameter int DATA_W = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] clean
);

    logic [DATA_W-1:0] sync_p0;
    logic [DATA_W-1:0] sync_p1;

    // Metastability filter: first flop may go metastable, second settles it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    assign clean = sync_p1;

endmodule

// File: rtl/evm_ballot_unit.sv
// Voter-facing ballot unit: debounces six candidate buttons, issues one
// single-cycle vote strobe per armed ballot, flags multi-button presses,
// locks out in result mode and counts ballots cast (saturating).
`timescale 1ns/1ps
module evm_ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       ballot_enable,
    input  logic       candidate1_button,
    input  logic       candidate2_button,
    input  logic       candidate3_button,
    input  logic       candidate4_button,
    input  logic       candidate5_button,
    input  logic       candidate6_button,
    output logic       vote_valid,
    output logic [2:0] vote_id,
    output logic [5:0] cand_pulse,
    output logic       ready_lamp,
    output logic       multi_press_err,
    output logic [7:0] ballots_cast
);

    // Counter value on the last stable cycle of a debounce window.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [NUM_CANDIDATES-1:0] raw_btn;
    logic [NUM_CANDIDATES-1:0] btn_s;
    logic                      en_s;
    logic                      en_d;
    logic                      en_rise;
    logic [2:0]                btn_count;

    state_t                    state;
    state_t                    next_state;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic [NUM_CANDIDATES-1:0] cand_q;
    logic [NUM_CANDIDATES-1:0] cand_next;
    logic                      fire;
    logic                      err_set;
    logic                      err_clr;

    logic                      vote_valid_d;
    logic [2:0]                vote_id_d;
    logic [5:0]                cand_pulse_d;
    logic                      ready_lamp_d;
    logic                      multi_press_err_d;
    logic [7:0]                ballots_cast_d;

    assign raw_btn = {candidate6_button, candidate5_button, candidate4_button,
                      candidate3_button, candidate2_button, candidate1_button};

    evm_sync2 #(.DATA_W(NUM_CANDIDATES)) u_sync_btn (
        .clock (clock),
        .reset (reset),
        .raw   (raw_btn),
        .clean (btn_s)
    );

    evm_sync2 #(.DATA_W(1)) u_sync_en (
        .clock (clock),
        .reset (reset),
        .raw   (ballot_enable),
        .clean (en_s)
    );

    // Delayed copy of the synchronized enable for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_d <= 1'b0;
        end else begin
            en_d <= en_s;
        end
    end

    assign en_rise   = en_s & ~en_d;
    assign btn_count = popcount(btn_s);

    // FSM state, shared debounce counter and latched candidate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= LOCKED;
            cnt    <= '0;
            cand_q <= '0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            cand_q <= cand_next;
        end
    end

    // Next-state logic; result mode overrides everything, including a due vote.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        cand_next  = cand_q;
        fire       = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (mode) begin
            next_state = LOCKED;
            cnt_next   = '0;
        end else begin
            case (state)
                LOCKED: begin
                    if (en_rise) begin
                        next_state = ARMED;
                        cnt_next   = '0;
                        err_clr    = 1'b1;
                    end
                end
                ARMED: begin
                    if (btn_count == 3'd1) begin
                        cand_next  = btn_s;
                        cnt_next   = CNT_W'(1);
                        next_state = PRESS;
                    end else if (btn_count >= 3'd2) begin
                        err_set = 1'b1;
                    end
                end
                PRESS: begin
                    if (btn_s == cand_q) begin
                        if (cnt == LAST_CNT) begin
                            fire       = 1'b1;
                            cnt_next   = '0;
                            next_state = RELEASE;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_next   = '0;
                        next_state = ARMED;
                        if (btn_count >= 3'd2) begin
                            err_set = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // Any bounce back to pressed restarts the clean-release window.
                    if (btn_s != '0) begin
                        cnt_next = '0;
                    end else if (cnt == LAST_CNT) begin
                        cnt_next   = '0;
                        next_state = LOCKED;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    next_state = LOCKED;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output decode: values the output registers take on the next edge.
    always_comb begin
        vote_valid_d      = fire;
        vote_id_d         = fire ? encode(cand_q) : 3'd0;
        cand_pulse_d      = fire ? cand_q : 6'd0;
        ready_lamp_d      = (next_state == ARMED) || (next_state == PRESS);
        multi_press_err_d = multi_press_err;
        if (err_clr) begin
            multi_press_err_d = 1'b0;
        end else if (err_set) begin
            multi_press_err_d = 1'b1;
        end
        ballots_cast_d    = fire ? sat_inc(ballots_cast) : ballots_cast;
    end

    // Registered outputs, so nothing combinational reaches the pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vote_valid      <= 1'b0;
            vote_id         <= 3'd0;
            cand_pulse      <= 6'd0;
            ready_lamp      <= 1'b0;
            multi_press_err <= 1'b0;
            ballots_cast    <= 8'd0;
        end else begin
            vote_valid      <= vote_valid_d;
            vote_id         <= vote_id_d;
            cand_pulse      <= cand_pulse_d;
            ready_lamp      <= ready_lamp_d;
            multi_press_err <= multi_press_err_d;
            ballots_cast    <= ballots_cast_d;
        end
    end

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed self-checking bench for evm_ballot_unit with DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_evm_ballot_unit;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic       ballot_enable = 1'b0;
    logic [5:0] btn = 6'd0;
    logic       vote_valid;
    logic [2:0] vote_id;
    logic [5:0] cand_pulse;
    logic       ready_lamp;
    logic       multi_press_err;
    logic [7:0] ballots_cast;

    int vectors = 0;
    int miscompares = 0;
    int vote_count = 0;
    int quiet_bad = 0;
    logic [2:0] last_id = 3'd0;
    logic [5:0] last_pulse = 6'd0;

    evm_ballot_unit #(.DEBOUNCE_CYCLES(DEB), .CNT_W(5)) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .ballot_enable     (ballot_enable),
        .candidate1_button (btn[0]),
        .candidate2_button (btn[1]),
        .candidate3_button (btn[2]),
        .candidate4_button (btn[3]),
        .candidate5_button (btn[4]),
        .candidate6_button (btn[5]),
        .vote_valid        (vote_valid),
        .vote_id           (vote_id),
        .cand_pulse        (cand_pulse),
        .ready_lamp        (ready_lamp),
        .multi_press_err   (multi_press_err),
        .ballots_cast      (ballots_cast)
    );

    always #5 clock = ~clock;

    // Record every strobe, and note any id/pulse activity outside a strobe.
    always @(negedge clock) begin
        if (vote_valid === 1'b1) begin
            vote_count = vote_count + 1;
            last_id    = vote_id;
            last_pulse = cand_pulse;
        end else if (vote_id !== 3'd0 || cand_pulse !== 6'd0) begin
            quiet_bad = quiet_bad + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic arm();
        ballot_enable = 1'b1;
        tick(4);
        ballot_enable = 1'b0;
        tick(1);
    endtask

    task automatic do_ballot(input logic [5:0] b);
        arm();
        btn = b;
        tick(7);
        btn = 6'd0;
        tick(9);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn = 6'd0;
        tick(3);
        vectors++; if (vote_valid !== 1'b0) begin miscompares++; $display("FAIL rst_vote_valid: got %0d want 0", vote_valid); end
        vectors++; if (vote_id !== 3'd0) begin miscompares++; $display("FAIL rst_vote_id: got %0d want 0", vote_id); end
        vectors++; if (cand_pulse !== 6'd0) begin miscompares++; $display("FAIL rst_cand_pulse: got %b want 000000", cand_pulse); end
        vectors++; if (multi_press_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0d want 0", multi_press_err); end
        reset = 1'b1;
        tick(2);
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0d want 0", ready_lamp); end
        vectors++; if (ballots_cast !== 8'd0) begin miscompares++; $display("FAIL rst_cast: got %0d want 0", ballots_cast); end
    endtask

    task automatic test_single_vote();
        int v0;
        arm();
        vectors++; if (ready_lamp !== 1'b1) begin miscompares++; $display("FAIL arm_ready: got %0d want 1", ready_lamp); end
        v0 = vote_count;
        btn = 6'b000010;
        tick(5);
        vectors++; if (vote_count !== v0) begin miscompares++; $display("FAIL single_early: got %0d votes want %0d", vote_count, v0); end
        tick(1);
        vectors++; if (vote_valid !== 1'b1) begin miscompares++; $display("FAIL single_strobe: got %0d want 1", vote_valid); end
        vectors++; if (vote_id !== 3'd2) begin miscompares++; $display("FAIL single_id: got %0d want 2", vote_id); end
        vectors++; if (cand_pulse !== 6'b000010) begin miscompares++; $display("FAIL single_pulse: got %b want 000010", cand_pulse); end
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL single_ready_fall: got %0d want 0", ready_lamp); end
        tick(1);
        vectors++; if (vote_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle: got %0d want 0", vote_valid); end
        tick(3);
        btn = 6'd0;
        tick(10);
        vectors++; if (vote_count !== v0 + 1) begin miscompares++; $display("FAIL single_count: got %0d want %0d", vote_count, v0 + 1); end
        vectors++; if (ballots_cast !== 8'd1) begin miscompares++; $display("FAIL single_cast: got %0d want 1", ballots_cast); end
    endtask

    task automatic test_bounce();
        int v0;
        logic pat [9];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        arm();
        v0 = vote_count;
        for (int i = 0; i < 9; i++) begin
            btn = pat[i] ? 6'b000001 : 6'b000000;
            tick(1);
        end
        vectors++; if (vote_count !== v0) begin miscompares++; $display("FAIL bounce_early: got %0d votes want %0d", vote_count, v0); end
        tick(2);
        vectors++; if (vote_valid !== 1'b1) begin miscompares++; $display("FAIL bounce_strobe: got %0d want 1", vote_valid); end
        vectors++; if (vote_id !== 3'd1) begin miscompares++; $display("FAIL bounce_id: got %0d want 1", vote_id); end
        tick(2);
        btn = 6'd0;
        tick(10);
        vectors++; if (vote_count !== v0 + 1) begin miscompares++; $display("FAIL bounce_count: got %0d want %0d", vote_count, v0 + 1); end
        vectors++; if (last_pulse !== 6'b000001) begin miscompares++; $display("FAIL bounce_pulse: got %b want 000001", last_pulse); end
        vectors++; if (ballots_cast !== 8'd2) begin miscompares++; $display("FAIL bounce_cast: got %0d want 2", ballots_cast); end
    endtask

    task automatic test_multi_press();
        int v0;
        arm();
        v0 = vote_count;
        btn = 6'b000110;
        tick(6);
        vectors++; if (multi_press_err !== 1'b1) begin miscompares++; $display("FAIL multi_err_set: got %0d want 1", multi_press_err); end
        vectors++; if (vote_count !== v0) begin miscompares++; $display("FAIL multi_no_vote: got %0d votes want %0d", vote_count, v0); end
        vectors++; if (ready_lamp !== 1'b1) begin miscompares++; $display("FAIL multi_ready: got %0d want 1", ready_lamp); end
        btn = 6'b000010;
        tick(6);
        vectors++; if (vote_valid !== 1'b1) begin miscompares++; $display("FAIL multi_strobe: got %0d want 1", vote_valid); end
        vectors++; if (vote_id !== 3'd2) begin miscompares++; $display("FAIL multi_id: got %0d want 2", vote_id); end
        tick(2);
        btn = 6'd0;
        tick(10);
        vectors++; if (vote_count !== v0 + 1) begin miscompares++; $display("FAIL multi_count: got %0d want %0d", vote_count, v0 + 1); end
        vectors++; if (multi_press_err !== 1'b1) begin miscompares++; $display("FAIL multi_err_sticky: got %0d want 1", multi_press_err); end
        vectors++; if (ballots_cast !== 8'd3) begin miscompares++; $display("FAIL multi_cast: got %0d want 3", ballots_cast); end
    endtask

    task automatic test_no_rearm();
        int v0;
        arm();
        vectors++; if (multi_press_err !== 1'b0) begin miscompares++; $display("FAIL rearm_err_clear: got %0d want 0", multi_press_err); end
        v0 = vote_count;
        btn = 6'b001000;
        tick(7);
        vectors++; if (vote_count !== v0 + 1) begin miscompares++; $display("FAIL rearm_first: got %0d votes want %0d", vote_count, v0 + 1); end
        vectors++; if (last_id !== 3'd4) begin miscompares++; $display("FAIL rearm_first_id: got %0d want 4", last_id); end
        ballot_enable = 1'b1;
        tick(4);
        ballot_enable = 1'b0;
        tick(2);
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL rearm_held_ready: got %0d want 0", ready_lamp); end
        tick(6);
        btn = 6'd0;
        tick(10);
        btn = 6'b010000;
        tick(10);
        vectors++; if (vote_count !== v0 + 1) begin miscompares++; $display("FAIL rearm_second_press: got %0d votes want %0d", vote_count, v0 + 1); end
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL rearm_locked_ready: got %0d want 0", ready_lamp); end
        btn = 6'd0;
        tick(10);
        arm();
        btn = 6'b010000;
        tick(6);
        vectors++; if (vote_valid !== 1'b1) begin miscompares++; $display("FAIL rearm_fresh_strobe: got %0d want 1", vote_valid); end
        vectors++; if (vote_id !== 3'd5) begin miscompares++; $display("FAIL rearm_fresh_id: got %0d want 5", vote_id); end
        tick(1);
        btn = 6'd0;
        tick(10);
        vectors++; if (ballots_cast !== 8'd5) begin miscompares++; $display("FAIL rearm_cast: got %0d want 5", ballots_cast); end
    endtask

    task automatic test_mode_lock();
        int v0;
        arm();
        v0 = vote_count;
        btn = 6'b100000;
        tick(5);
        mode = 1'b1;
        tick(1);
        vectors++; if (vote_valid !== 1'b0) begin miscompares++; $display("FAIL mode_suppress: got %0d want 0", vote_valid); end
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL mode_locked: got %0d want 0", ready_lamp); end
        tick(4);
        ballot_enable = 1'b1;
        tick(4);
        ballot_enable = 1'b0;
        tick(2);
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL mode_en_ignored: got %0d want 0", ready_lamp); end
        btn = 6'd0;
        tick(2);
        mode = 1'b0;
        tick(10);
        vectors++; if (ready_lamp !== 1'b0) begin miscompares++; $display("FAIL mode_after_ready: got %0d want 0", ready_lamp); end
        vectors++; if (vote_count !== v0) begin miscompares++; $display("FAIL mode_no_vote: got %0d votes want %0d", vote_count, v0); end
        vectors++; if (ballots_cast !== 8'd5) begin miscompares++; $display("FAIL mode_cast: got %0d want 5", ballots_cast); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 249; i++) begin
            do_ballot(6'b000001);
        end
        vectors++; if (ballots_cast !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d want 254", ballots_cast); end
        for (int i = 0; i < 3; i++) begin
            do_ballot(6'b000001);
        end
        vectors++; if (ballots_cast !== 8'd255) begin miscompares++; $display("FAIL sat_255: got %0d want 255", ballots_cast); end
        vectors++; if (vote_count !== 257) begin miscompares++; $display("FAIL sat_strobes: got %0d want 257", vote_count); end
        vectors++; if (quiet_bad !== 0) begin miscompares++; $display("FAIL quiet_outputs: got %0d idle cycles with id/pulse set, want 0", quiet_bad); end
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_bounce();
        test_multi_press();
        test_no_rearm();
        test_mode_lock();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
